recv: RTL and testbench
=======================

Name: recv

Overview:
UART receiver, 8N1, LSB first: the receive side of the existing `send` transmitter, using the same bit-time parameter, so a looped-back `send` output decodes cleanly.
- Samples the asynchronous serial line, finds the start bit, samples each bit at mid-period and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe.
- Sits beside `send` in top, driven by PHYSICAL_UART_RX and PHYSICAL_CLOCK; its output feeds cpu input or LED debug.

Parameters:
wtime, 32'h28B0, clock cycles per bit (10416 at 100 MHz, i.e. 9600 baud); must be >= 8.

Ports:
CLK  input  1  system clock (100 MHz)
RESET  input  1  synchronous, active-high reset
UART_RX  input  1  asynchronous serial line; idles high
data  output  8  last correctly framed byte; held until the next good frame
valid  output  1  one-cycle pulse: data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high. The clock port is CLK, the reset port is RESET.
- Synchronizer: two flops, rx_s = UART_RX delayed 2 cycles; both flops reset to 1.
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, ct=0, bit index=0, shift register=0.
- RESET has priority in every state; reset mid-frame aborts with no valid or frame_err.
- ct is a 32-bit counter; half = wtime>>1 (truncating).
- IDLE:
  - rx_s==0 -> START, ct<=0.
- START:
  - ct increments each cycle.
  - At ct==half-1: rx_s==0 -> DATA with ct<=0, idx<=0; rx_s==1 -> IDLE (glitch rejected, no flag).
- DATA:
  - ct increments each cycle.
  - At ct==wtime-1: shift register <= {sample, sh[7:1]} (LSB first), ct<=0, idx<=idx+1.
  - After the sample with idx==7 -> STOP.
- STOP:
  - At ct==wtime-1 with sample==1: data<=shift register, valid=1 for that cycle, -> IDLE.
  - At ct==wtime-1 with sample==0: frame_err=1 for that cycle, data unchanged, -> BREAK.
- BREAK: remain until rx_s==1, then IDLE (a held-low break line yields exactly one frame_err).
- valid and frame_err are registered and are never high in the same cycle.
- Latency, with cycle 0 = first cycle rx_s==0: valid asserts at end of cycle half + 9*wtime (+/-1 cycle, registered). Because sampling is mid-bit, STOP exits about wtime/2 before the stop bit ends, so back-to-back frames with a 1-bit stop are accepted.
- Sample point: each bit is sampled half a period after its leading edge.
- Re-arm: the next start bit is detected on the first rx_s==0 in IDLE. No start edge is required after a good stop.

Optional Feature:
Macro: RECV_MAJORITY_EN
- Defined:
  - sample = 2-of-3 majority of rx_s at the current cycle and the two previous cycles (3-bit history, reset to 3'b111).
  - Applies to the start check, data bits and stop bit.
  - Majority adds no latency to state transitions.
- Undefined: sample = rx_s.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t.
  - localparam logic [31:0] UART_WTIME_DEFAULT = 32'h28B0.
  - localparam int UART_DATA_BITS = 8.
  - `send` is to be migrated to the same default.
- One sub-module, rx_sync: 2-flop synchronizer plus the optional majority history. Output is sample and rx_s; it takes CLK and RESET.

Test Plan (wtime=16 unless noted):
- Byte 8'hA5, ideal timing, 1 stop bit -> data==8'hA5, valid high exactly 1 cycle, frame_err never high, busy low afterwards.
- Low glitch of 3 cycles on idle line -> return to IDLE within half+3 cycles; no valid, no frame_err.
- Frame 8'h3C with stop bit driven 0, line held low 40 cycles, then idle, then byte 8'hC3 -> one frame_err pulse, data stays at its previous value, then data==8'hC3 with valid.
- Back-to-back 8'h00, 8'hFF, 8'h81 with zero idle gap -> three valid pulses spaced 10*wtime apart, bytes in order.
- RESET asserted for 1 cycle at mid bit 4 of 8'h55, then 8'h96 sent -> no output for 8'h55; data==8'h96 valid.
- Loopback from send #(16) with data=8'h5A (and wtime=32'h28B0 for one frame) -> repeated valid pulses, each with data==8'h5A, no frame_err. With RECV_MAJORITY_EN, a 1-cycle inverted spike at each bit centre still yields 8'h5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit time and
// frame width. The matching transmitter (send) is to be moved to the same
// default bit time.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam logic [31:0] UART_WTIME_DEFAULT = 32'h28B0;
    localparam int          UART_DATA_BITS     = 8;

    // 2-of-3 vote used to reject single-cycle spikes on the line
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/recv_rx_sync.sv
// Line conditioning for the UART receiver: a two-flop synchronizer for the
// asynchronous serial input, plus an optional three-sample majority vote.
// Build option: define RECV_MAJORITY_EN to enable the majority vote;
// otherwise sample is the synchronized line itself.
module rx_sync
    import uart_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic UART_RX,
    output logic sample,
    output logic rx_s
);

`ifdef RECV_MAJORITY_EN
    logic       meta;
    // hist[0] is the second synchronizer flop; hist[2:1] are the two
    // previous synchronized values
    logic [2:0] hist;

    // Synchronize the line and keep the last three synchronized samples
    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= 1'b1;
            hist <= 3'b111;
        end else begin
            meta <= UART_RX;
            hist <= {hist[1:0], meta};
        end
    end

    assign rx_s   = hist[0];
    assign sample = maj3(hist[0], hist[1], hist[2]);
`else
    logic meta;
    logic sync;

    // Synchronize the line through two flops, idling high
    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= UART_RX;
            sync <= meta;
        end
    end

    assign rx_s   = sync;
    assign sample = sync;
`endif

endmodule

// File: rtl/recv.sv
// UART receiver, 8N1, LSB first. Finds the start bit on the synchronized
// line, samples each bit half a bit time after its leading edge, checks the
// stop bit and presents each good byte with a one-cycle valid strobe.
// Build option: RECV_MAJORITY_EN selects a 2-of-3 majority sample (see rx_sync).
module recv
    import uart_pkg::*;
#(
    parameter logic [31:0] wtime = UART_WTIME_DEFAULT
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [31:0] HALF     = wtime >> 1;
    localparam logic [31:0] HALF_M1  = HALF - 32'd1;
    localparam logic [31:0] WTIME_M1 = wtime - 32'd1;
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic sample;
    logic rx_s;

    rx_state_t                   state, state_d;
    logic [31:0]                 ct, ct_d;
    logic [2:0]                  idx, idx_d;
    logic [UART_DATA_BITS-1:0]   sh, sh_d;
    logic [7:0]                  data_d;
    logic                        valid_d;
    logic                        ferr_d;

    rx_sync u_rx_sync (
        .CLK     (CLK),
        .RESET   (RESET),
        .UART_RX (UART_RX),
        .sample  (sample),
        .rx_s    (rx_s)
    );

    // Register state, counters, shift register and the output strobes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            ct        <= 32'd0;
            idx       <= 3'd0;
            sh        <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            ct        <= ct_d;
            idx       <= idx_d;
            sh        <= sh_d;
            data      <= data_d;
            valid     <= valid_d;
            frame_err <= ferr_d;
        end
    end

    // Next-state, bit timing and frame assembly
    always_comb begin
        state_d = state;
        ct_d    = ct;
        idx_d   = idx;
        sh_d    = sh;
        data_d  = data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state)
            IDLE: begin
                ct_d = 32'd0;
                // No start edge is needed: any low level re-arms the frame
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (ct == HALF_M1) begin
                    // Middle of the start bit: still low means a real frame,
                    // high means a glitch that is silently dropped
                    ct_d    = 32'd0;
                    idx_d   = 3'd0;
                    state_d = sample ? IDLE : DATA;
                end else begin
                    ct_d = ct + 32'd1;
                end
            end

            DATA: begin
                if (ct == WTIME_M1) begin
                    ct_d  = 32'd0;
                    sh_d  = {sample, sh[UART_DATA_BITS-1:1]};
                    idx_d = idx + 3'd1;
                    if (idx == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    ct_d = ct + 32'd1;
                end
            end

            STOP: begin
                if (ct == WTIME_M1) begin
                    ct_d = 32'd0;
                    // Leaving at mid stop bit lets a back-to-back start bit
                    // be caught immediately
                    if (sample) begin
                        data_d  = sh;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    ct_d = ct + 32'd1;
                end
            end

            BREAK: begin
                ct_d = 32'd0;
                // Hold here while the line stays low so a break gives one error
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_recv.sv
// Directed test for the UART receiver with a 16-cycle bit time.
module tb_recv;

    localparam int W = 16;

    logic       CLK;
    logic       RESET;
    logic       UART_RX;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         t_q[$];
    int         ferr_cnt = 0;
    int         dbl_cnt = 0;
    int         both_cnt = 0;
    logic       valid_prev = 1'b0;

    recv #(.wtime(32'd16)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .UART_RX   (UART_RX),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every output strobe, sampled on the falling edge
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (valid) begin
            rx_q.push_back(data);
            t_q.push_back(cyc);
        end
        if (valid && valid_prev) dbl_cnt = dbl_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (valid && frame_err) both_cnt = both_cnt + 1;
        valid_prev = valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drive one bit for W cycles; optionally flip the line for one cycle mid-bit
    task automatic drive_bit(input logic b, input bit spike);
        UART_RX = b;
        if (spike) begin
            repeat (W/2) @(negedge CLK);
            UART_RX = ~b;
            @(negedge CLK);
            UART_RX = b;
            repeat (W/2 - 1) @(negedge CLK);
        end else begin
            repeat (W) @(negedge CLK);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit spike);
        drive_bit(1'b0, spike);
        for (int i = 0; i < 8; i++) drive_bit(b[i], spike);
        drive_bit(stop_bit, spike);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int f0;
        UART_RX = 1'b1;
        RESET   = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_ferr", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        RESET = 1'b0;
        idle(4);

        // Single byte, ideal timing
        send_byte(8'hA5, 1'b1, 1'b0);
        idle(2*W);
        check("a5_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("a5_byte", {24'd0, rx_q[0]}, 32'hA5);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_width", dbl_cnt, 0);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_busy", {31'd0, busy}, 0);

        // Three-cycle low glitch on the idle line
        UART_RX = 1'b0;
        repeat (3) @(negedge CLK);
        UART_RX = 1'b1;
        repeat (W/2 + 3 + 3) @(negedge CLK);
        check("glitch_busy", {31'd0, busy}, 0);
        idle(W);
        check("glitch_count", rx_q.size(), 1);
        check("glitch_ferr", ferr_cnt, 0);

        // Framing error with the line held low, then a good byte
        send_byte(8'h3C, 1'b0, 1'b0);
        UART_RX = 1'b0;
        repeat (40) @(negedge CLK);
        check("brk_busy", {31'd0, busy}, 1);
        idle(2*W);
        check("brk_ferr", ferr_cnt, 1);
        check("brk_count", rx_q.size(), 1);
        check("brk_data", {24'd0, data}, 32'hA5);
        check("brk_idle", {31'd0, busy}, 0);
        send_byte(8'hC3, 1'b1, 1'b0);
        idle(2*W);
        check("c3_count", rx_q.size(), 2);
        check("c3_data", {24'd0, data}, 32'hC3);
        check("c3_ferr", ferr_cnt, 1);

        // Back-to-back frames, no idle gap
        n0 = rx_q.size();
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h81, 1'b1, 1'b0);
        idle(2*W);
        check("b2b_count", rx_q.size() - n0, 3);
        if (rx_q.size() == n0 + 3) begin
            check("b2b_b0", {24'd0, rx_q[n0]},   32'h00);
            check("b2b_b1", {24'd0, rx_q[n0+1]}, 32'hFF);
            check("b2b_b2", {24'd0, rx_q[n0+2]}, 32'h81);
            check("b2b_gap0", t_q[n0+1] - t_q[n0],   10*W);
            check("b2b_gap1", t_q[n0+2] - t_q[n0+1], 10*W);
        end
        check("b2b_ferr", ferr_cnt, 1);

        // Reset in the middle of bit 4 of 8'h55 aborts the frame
        n0 = rx_q.size();
        f0 = ferr_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i), 1'b0);
        UART_RX = 1'b1;
        repeat (W/2) @(negedge CLK);
        check("mid_busy", {31'd0, busy}, 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_data", {24'd0, data}, 32'h00);
        idle(12*W);
        check("mid_none", rx_q.size() - n0, 0);
        send_byte(8'h96, 1'b1, 1'b0);
        idle(2*W);
        check("r96_count", rx_q.size() - n0, 1);
        check("r96_data", {24'd0, data}, 32'h96);
        check("r96_ferr", ferr_cnt - f0, 0);

        // Repeated 8'h5A frames, as a looped-back transmitter would send
        n0 = rx_q.size();
        send_byte(8'h5A, 1'b1, 1'b0);
        idle(W);
        send_byte(8'h5A, 1'b1, 1'b0);
        idle(2*W);
        check("lb_count", rx_q.size() - n0, 2);
        if (rx_q.size() == n0 + 2) begin
            check("lb_b0", {24'd0, rx_q[n0]},   32'h5A);
            check("lb_b1", {24'd0, rx_q[n0+1]}, 32'h5A);
        end
        check("lb_ferr", ferr_cnt - f0, 0);

`ifdef RECV_MAJORITY_EN
        // One-cycle inverted spike in every bit is voted out
        n0 = rx_q.size();
        send_byte(8'h5A, 1'b1, 1'b1);
        idle(2*W);
        check("spk_count", rx_q.size() - n0, 1);
        check("spk_data", {24'd0, data}, 32'h5A);
        check("spk_ferr", ferr_cnt - f0, 0);
`endif

        check("never_both", both_cnt, 0);
        check("pulse_width", dbl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
